serial_weight_loader: RTL
=========================

// Module: serial_weight_loader
// PURPOSE
//  Deserialises a 1-bit synapse-weight stream into a ROWS x COLS matrix of W-bit weights for the ONN neuron array.
//  Parametrised successor of the fixed 5x3x4-bit control_to_neuron weight path.
//  Adds framing (start), a per-bit valid qualifier and selectable bit order.
//  Adds a shadow/active double buffer, so the neurons see a new matrix only after a whole frame has been received.
// PARAMETERS
//  ROWS       5  matrix rows (>=1)
//  COLS       3  matrix columns (>=1)
//  W          4  bits per weight (>=1)
//  MSB_FIRST  1  1: first bit of each word lands in bit W-1; 0: first bit lands in bit 0
// PORTS
//  clk          in   1             system clock, all state on rising edge
//  rst_n        in   1             asynchronous, active-low reset
//  start        in   1             frame-start strobe
//  bit_in       in   1             serial weight data
//  bit_valid    in   1             bit_in is sampled on this edge when high
//  weights_out  out  ROWS*COLS*W   active matrix; word k=r*COLS+c at [k*W +: W]
//  busy         out  1             high in LOAD and COMMIT
//  load_done    out  1             1-cycle pulse when weights_out is updated
//  frame_abort  out  1             1-cycle pulse when a frame in progress is restarted
// BEHAVIOUR
//  Reset (async, rst_n=0):
//  - state=IDLE; shadow, weights_out, bit/word counters, busy, load_done and frame_abort all go to 0.
//  FSM IDLE -> LOAD -> COMMIT -> IDLE:
//  - IDLE: start=1 -> LOAD, with bit_cnt=0, word_cnt=0. bit_valid is ignored in IDLE, including on the start cycle.
//  - LOAD: each edge with bit_valid=1 shifts bit_in into the word shift register and increments bit_cnt.
//    - MSB_FIRST=1: shift left, new bit at LSB. Four bits b0..b3 give word {b0,b1,b2,b3}.
//    - MSB_FIRST=0: shift right, new bit at MSB. Four bits b0..b3 give word {b3,b2,b1,b0}.
//  - On the W-th bit: the completed word (including the bit on that edge) is written to shadow[word_cnt]; bit_cnt returns to 0; word_cnt increments.
//  - On the last bit of word ROWS*COLS-1: -> COMMIT.
//  - bit_valid=0 in LOAD: hold all state. Gaps of any length are legal.
//  - start=1 in LOAD has priority over bit_valid:
//    - counters return to 0 and the state stays LOAD; the bit on that edge is discarded;
//    - frame_abort pulses the next cycle;
//    - shadow is not cleared, but a full new frame overwrites every entry;
//    - weights_out is untouched.
//  - COMMIT (exactly 1 cycle): weights_out <= shadow; load_done=1 for the following cycle; -> IDLE.
//    - start and bit_valid are ignored during COMMIT.
//  Latency:
//  - The last frame bit is accepted at edge E. weights_out changes and load_done rises at edge E+1.
//  - busy falls at edge E+1, so the earliest next start is sampled at E+1.
//  Other rules:
//  - A frame takes ROWS*COLS*W valid bits. Counters are $clog2-sized, with a minimum width of 1. No wrap past the last word.
//  - weights_out never shows a partial frame. Reset mid-frame discards the frame and clears weights_out to 0.
// TESTING
//  T1: defaults, MSB_FIRST=1.
//   - Stimulus: start, then 60 valid bits = twelve 1s, eight 0s, twenty 1s, eight 0s, twelve 1s.
//   - Expected words k0..k14: F,F,F,0,0,F,F,F,F,F,0,0,F,F,F.
//   - load_done pulses once at E+1; busy is high for 61 cycles.
//  T2: MSB_FIRST=0, W=4, ROWS=COLS=1.
//   - Stimulus: start, bits 1,0,0,0.
//   - Expected: weights_out=4'b0001, versus 4'b1000 for MSB_FIRST=1.
//  T3: T1 stream with bit_valid=0 for 3 cycles after every 7th bit.
//   - Expected: weights_out identical to T1; load_done is delayed by the gap count only.
//  T4: restart mid-frame.
//   - Stimulus: frame of all 1s, committed. Then start, 30 bits of 0, start again, 60 bits of 0x5 words.
//   - Expected: frame_abort pulses once; weights_out stays all-F until commit, then every word=5.
//  T5: reset mid-frame.
//   - Stimulus: rst_n=0 asynchronously (mid-clock) after bit 40.
//   - Expected: all outputs 0 immediately. After release, start plus a full frame commits normally.
//  T6: corner cases.
//   - bit_valid=1 on the start edge and during COMMIT: those bits are ignored, and the frame aligns to the next bits.
//   - ROWS=1, COLS=1, W=1: a single bit commits.

Source files
------------

// File: rtl/serial_weight_loader.sv
`timescale 1ns/1ps
// serial_weight_loader: deserialises a 1-bit weight stream into a ROWS x COLS matrix of W-bit words.
// Latency: the last frame bit is accepted at edge E; weights_out updates and load_done pulses at E+1.
// Backpressure: none; bit_valid qualifies each bit, gaps of any length hold state, busy flags LOAD/COMMIT.
//
// Ports:
//   clk, rst_n         clock (rising edge) and asynchronous active-low reset
//   start              frame-start strobe (restarts a frame already in progress)
//   bit_in, bit_valid  serial data and its per-edge qualifier
//   weights_out        active matrix, word k = r*COLS + c at [k*W +: W]
//   busy               high while loading or committing
//   load_done          1-cycle pulse when weights_out has been updated
//   frame_abort        1-cycle pulse when a frame in progress was restarted
module serial_weight_loader #(
  parameter int ROWS      = 5,
  parameter int COLS      = 3,
  parameter int W         = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     bit_in,
  input  logic                     bit_valid,
  output logic [ROWS*COLS*W-1:0]   weights_out,
  output logic                     busy,
  output logic                     load_done,
  output logic                     frame_abort
);

  localparam int NWORDS = ROWS * COLS;
  localparam int BCW    = (W > 1) ? $clog2(W) : 1;
  localparam int WCW    = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [BCW-1:0] BIT_LAST  = BCW'(W - 1);
  localparam logic [WCW-1:0] WORD_LAST = WCW'(NWORDS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [BCW-1:0]      bit_cnt;
  logic [WCW-1:0]      word_cnt;
  logic [W-1:0]        word_nxt;
  logic [NWORDS*W-1:0] shadow;

  logic frame_go;   // start accepted in IDLE
  logic restart;    // start seen while a frame is in progress
  logic accept;     // a bit is taken on this edge
  logic word_end;   // accepted bit completes the current word
  logic frame_end;  // accepted bit completes the last word

  // The W-th bit of a word is taken straight from bit_in, so only W-1
  // partial bits ever need to be held between edges.
  if (W == 1) begin : g_w1
    assign word_nxt = bit_in;
  end else begin : g_shift
    logic [W-2:0] part;

    if (MSB_FIRST) begin : g_msb
      assign word_nxt = {part, bit_in};
    end else begin : g_lsb
      assign word_nxt = {bit_in, part};
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        part <= '0;
      end else if (accept) begin
        part <= MSB_FIRST ? word_nxt[W-2:0] : word_nxt[W-1:1];
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    if (frame_end) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    busy      = (state != IDLE);
    frame_go  = (state == IDLE) && start;
    restart   = (state == LOAD) && start;
    // start has priority: the bit on a restart edge is dropped
    accept    = (state == LOAD) && !start && bit_valid;
    word_end  = accept && (bit_cnt == BIT_LAST);
    frame_end = word_end && (word_cnt == WORD_LAST);
  end

  // Datapath: counters, shadow buffer, active matrix and pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt     <= '0;
      word_cnt    <= '0;
      shadow      <= '0;
      weights_out <= '0;
      load_done   <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      load_done   <= (state == COMMIT);
      frame_abort <= restart;

      if (frame_go || restart) begin
        bit_cnt  <= '0;
        word_cnt <= '0;
      end else if (accept) begin
        if (word_end) begin
          shadow[int'(word_cnt)*W +: W] <= word_nxt;
          bit_cnt <= '0;
          // Hold on the last word; the next start clears it anyway.
          if (!frame_end) begin
            word_cnt <= word_cnt + 1'b1;
          end
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end

      // Neurons only ever see a completed frame.
      if (state == COMMIT) begin
        weights_out <= shadow;
      end
    end
  end

endmodule
